uart_rx_oversampled: RTL and testbench
======================================

# uart_rx_oversampled

UART receive stage that consumes the 16x-oversampling `uart_tick` from the baud-rate generator and recovers bytes from the asynchronous serial line. It synchronizes `rx`, detects the start bit, samples each bit at its centre, checks the stop bit and presents each byte with a one-cycle `rx_done` strobe to downstream logic (FIFO or command parser). Frame format is fixed: 1 start bit, DATA_BITS data bits LSB first, no parity, 1 stop bit.

## Interface
- `DATA_BITS`, default 8: data bits per frame (5–8).
- `OVERSAMPLE`, default 16: `uart_tick` pulses per bit period; must be even.
- `clk`  in  1  system clock (100 MHz nominal).
- `reset`  in  1  synchronous, active-high; clock `clk`.
- `uart_tick`  in  1  single-cycle enable, OVERSAMPLE per bit period.
- `rx`  in  1  asynchronous serial input, idle high.
- `rx_data`  out  DATA_BITS  last received byte.
- `rx_done`  out  1  one-cycle strobe, `rx_data`/`frame_error` valid.
- `frame_error`  out  1  stop bit sampled low on last frame.
- `rx_busy`  out  1  high whenever FSM is not IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1); FSM uses only the synchronized value `rx_s`.
- Counters: `s` (tick count, 0..OVERSAMPLE-1), `n` (bit index, 0..DATA_BITS-1); both advance only on cycles with `uart_tick`=1.
- IDLE: on any cycle with `rx_s`=0 → START, `s`=0 (tick not required to enter).
- START: on tick, if `s`=OVERSAMPLE/2-1: `rx_s`=0 → DATA, `s`=0, `n`=0; `rx_s`=1 → IDLE (false start, no strobe). Else `s`++.
- DATA: on tick, if `s`=OVERSAMPLE-1: `s`=0, shift register ← {`rx_s`, shreg[DATA_BITS-1:1]} (LSB first); if `n`=DATA_BITS-1 → STOP else `n`++. Else `s`++.
- STOP: on tick, if `s`=OVERSAMPLE-1: `rx_data` ← shreg, `frame_error` ← ~`rx_s`, `rx_done` ← 1, → IDLE. Else `s`++.
- Byte is delivered even on framing error; `frame_error` flags it.
- `rx_data` and `frame_error` hold until the next `rx_done`.
- A low stop bit (break) returns to IDLE, then immediately re-enters START since `rx_s`=0; no lockout.

## Timing
- Reset values: `rx_data`=0, `rx_done`=0, `frame_error`=0, `rx_busy`=0, FSM=IDLE, `s`=`n`=0, shreg=0.
- Reset mid-frame aborts the frame: no strobe, all outputs to reset values next cycle.
- Synchronizer latency 2 clk from `rx` edge to `rx_s`.
- Sampling points: start bit at OVERSAMPLE/2 ticks after detection; each data/stop bit OVERSAMPLE ticks after the previous sample (bit centre).
- `rx_done` is registered: high for exactly one `clk` cycle, the cycle after the tick that samples the stop bit; never high on consecutive cycles.
- `rx_busy` high from the cycle after `rx_s` falls in IDLE until the cycle `rx_done` asserts (inclusive drop to 0 with it), or until a false-start return.
- Back-to-back frames: next start bit may fall directly after the stop-bit centre; it is accepted.
- Counter widths: `s` = clog2(OVERSAMPLE), `n` = clog2(DATA_BITS); no wrap beyond terminal values.

## Test plan
Bench: 100 MHz clk, baud generator divisor 54 (bit period 864 clk), DATA_BITS=8.
- Frame 0xA5, valid stop -> one `rx_done` pulse, `rx_data`=0xA5, `frame_error`=0, `rx_busy` low afterwards.
- Back-to-back 0x00 then 0xFF, no idle gap -> two strobes, `rx_data`=0x00 then 0xFF, `frame_error`=0 both.
- `rx` low glitch of 3 ticks (162 clk) then high -> no `rx_done`, `rx_busy` returns 0, `rx_data` unchanged.
- Frame 0x3C with stop bit driven 0 -> `rx_done`=1, `rx_data`=0x3C, `frame_error`=1; following clean 0x81 clears `frame_error` to 0.
- `reset` asserted 1 cycle during bit 4 of 0xFF, then clean 0x5A -> no strobe for aborted frame, outputs 0 after reset, then `rx_data`=0x5A.
- Sender baud ±3% (bit period 838 / 890 clk), 0x55 -> `rx_data`=0x55, `frame_error`=0 in both cases.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// UART receiver fed by a 16x oversampling tick: synchronizes rx, finds the start
// bit, samples each bit at its centre and strobes rx_done with frame_error per frame.
module uart_rx_oversampled #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_error,
  output logic                 rx_busy
);

  localparam int unsigned SW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned NW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e               state_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic [SW-1:0]        s_q;
  logic [NW-1:0]        n_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_done_q;
  logic                 frame_error_q;
  logic                 rx_busy_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      s_q           <= '0;
      n_q           <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rx_done_q     <= 1'b0;
      frame_error_q <= 1'b0;
      rx_busy_q     <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_q   <= ST_START;
            s_q       <= '0;
            rx_busy_q <= 1'b1;
          end
        end
        // Half a bit in: confirm the start bit is still low, else treat as glitch.
        ST_START: begin
          if (uart_tick) begin
            if (s_q == S_MID) begin
              if (!rx_s_q) begin
                state_q <= ST_DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q   <= ST_IDLE;
                rx_busy_q <= 1'b0;
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        ST_DATA: begin
          if (uart_tick) begin
            if (s_q == S_LAST) begin
              s_q     <= '0;
              shreg_q <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
              if (n_q == N_LAST) begin
                state_q <= ST_STOP;
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        // Byte is delivered even with a low stop bit; frame_error marks it.
        ST_STOP: begin
          if (uart_tick) begin
            if (s_q == S_LAST) begin
              rx_data_q     <= shreg_q;
              frame_error_q <= ~rx_s_q;
              rx_done_q     <= 1'b1;
              rx_busy_q     <= 1'b0;
              state_q       <= ST_IDLE;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_done     = rx_done_q;
  assign frame_error = frame_error_q;
  assign rx_busy     = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: serial frames with random tick phase and baud skew,
// scored against a frame-level model that predicts each strobe's cycle, byte and error flag.
module tb_uart_rx_oversampled;

  localparam int unsigned NB       = 8;
  localparam int unsigned OS       = 16;
  localparam int unsigned TICK_DIV = 54;
  localparam int unsigned NOM_BIT  = OS * TICK_DIV;
  // Ticks from START entry to the stop-bit sample: half a bit, then data bits plus stop.
  localparam int unsigned FRAME_TICKS = OS / 2 + (NB + 1) * OS;

  typedef struct packed {
    logic [NB-1:0] data;
    logic          fe;
    logic [31:0]   done_cyc;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          uart_tick;
  logic          rx;
  logic [NB-1:0] rx_data;
  logic          rx_done;
  logic          frame_error;
  logic          rx_busy;

  int unsigned cyc;
  logic        rst_prev;
  int          n_vec;
  int          n_err;
  exp_t        q[$];
  logic [NB-1:0] held_data;
  logic          held_fe;

  uart_rx_oversampled #(.DATA_BITS(NB), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_tick  (uart_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .frame_error(frame_error),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc      = 0;
    rst_prev = 1'b1;
  end

  always @(posedge clk) begin
    cyc      = cyc + 1;
    rst_prev = reset;
  end

  // Baud generator: a tick is seen on every posedge whose index is a multiple of TICK_DIV.
  initial begin
    uart_tick = 1'b0;
    forever begin
      @(negedge clk);
      uart_tick = ((cyc + 1) % TICK_DIV) == 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Falling edge set after posedge c: rx_s low after edge c+2, START after edge c+3,
  // then the stop sample lands on the FRAME_TICKS-th tick edge beyond that.
  function automatic logic [31:0] done_of(input int unsigned c);
    int unsigned first_tick;
    first_tick = ((c + 3) / TICK_DIV + 1) * TICK_DIV;
    return 32'(first_tick + (FRAME_TICKS - 1) * TICK_DIV);
  endfunction

  always @(negedge clk) begin : compare
    exp_t e;
    if (rst_prev) begin
      held_data = '0;
      held_fe   = 1'b0;
      check("reset_outputs", 32'({rx_done, rx_busy, frame_error, rx_data}), 32'(0));
    end else if (q.size() > 0 && cyc == q[0].done_cyc) begin
      e         = q.pop_front();
      held_data = e.data;
      held_fe   = e.fe;
      check("strobe_done_busy_fe_data", 32'({rx_done, rx_busy, frame_error, rx_data}),
            32'({1'b1, 1'b0, e.fe, e.data}));
    end else begin
      check("hold_done_fe_data", 32'({rx_done, frame_error, rx_data}),
            32'({1'b0, held_fe, held_data}));
    end
  end

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives one frame and books its expected strobe unless aborted.
  task automatic send_frame(input logic [NB-1:0] data, input bit stop_ok,
                            input int unsigned period, input int abort_bit);
    logic [NB+1:0] bits;
    exp_t          e;
    int unsigned   len;
    bits = {stop_ok ? 1'b1 : 1'b0, data, 1'b0};
    if (abort_bit < 0) begin
      e.data     = data;
      e.fe       = !stop_ok;
      e.done_cyc = done_of(cyc);
      q.push_back(e);
    end
    for (int i = 0; i < NB + 2; i++) begin
      rx  = bits[i];
      // A low stop bit is held past its sample point, then released well before a re-start check.
      len = (i == NB + 1 && !stop_ok) ? period / 2 + 250 : period;
      repeat (len / 2) @(negedge clk);
      if (i == 3) check("busy_mid_frame", 32'(rx_busy), 32'(1));
      if (abort_bit >= 0 && i == abort_bit + 1) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        len   = len - 1;
      end
      repeat (len - len / 2) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic expect_idle(input string name, input logic [NB-1:0] data, input logic fe);
    check({name, "_data"}, 32'(rx_data), 32'(data));
    check({name, "_fe"}, 32'(frame_error), 32'(fe));
    check({name, "_busy"}, 32'(rx_busy), 32'(0));
  endtask

  initial begin
    logic [NB-1:0] rdata;
    bit            rstop;
    int unsigned   rper;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(100 + $urandom_range(0, TICK_DIV - 1));

    send_frame(8'hA5, 1'b1, NOM_BIT, -1);
    idle(200 + $urandom_range(0, TICK_DIV - 1));
    expect_idle("a5", 8'hA5, 1'b0);

    send_frame(8'h00, 1'b1, NOM_BIT, -1);
    send_frame(8'hFF, 1'b1, NOM_BIT, -1);
    idle(200 + $urandom_range(0, TICK_DIV - 1));
    expect_idle("b2b_ff", 8'hFF, 1'b0);

    rx = 1'b0;
    repeat (50) @(negedge clk);
    check("glitch_busy", 32'(rx_busy), 32'(1));
    repeat (3 * TICK_DIV - 50) @(negedge clk);
    idle(1000);
    expect_idle("glitch", 8'hFF, 1'b0);

    send_frame(8'h3C, 1'b0, NOM_BIT, -1);
    idle(400 + $urandom_range(0, TICK_DIV - 1));
    expect_idle("bad_stop_3c", 8'h3C, 1'b1);

    send_frame(8'h81, 1'b1, NOM_BIT, -1);
    idle(200 + $urandom_range(0, TICK_DIV - 1));
    expect_idle("clean_81", 8'h81, 1'b0);

    send_frame(8'hFF, 1'b1, NOM_BIT, 4);
    idle(200 + $urandom_range(0, TICK_DIV - 1));
    expect_idle("after_abort", 8'h00, 1'b0);

    send_frame(8'h5A, 1'b1, NOM_BIT, -1);
    idle(200 + $urandom_range(0, TICK_DIV - 1));
    expect_idle("post_reset_5a", 8'h5A, 1'b0);

    send_frame(8'h55, 1'b1, 838, -1);
    idle(200 + $urandom_range(0, TICK_DIV - 1));
    expect_idle("fast_55", 8'h55, 1'b0);

    send_frame(8'h55, 1'b1, 890, -1);
    idle(200 + $urandom_range(0, TICK_DIV - 1));
    expect_idle("slow_55", 8'h55, 1'b0);

    rdata = NB'($urandom_range(0, 255));
    rstop = $urandom_range(0, 3) != 0;
    rper  = rstop ? $urandom_range(838, 890) : NOM_BIT;
    send_frame(rdata, rstop, rper, -1);
    idle(400);

    idle(200);
    check("pending_strobes", 32'(q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
